// File: rtl/t_ff_burst_ctrl.sv
// Toggle flip-flop burst sequencer: issues COUNT single-cycle T pulses spaced PERIOD cycles apart.
// Optional abort input is compiled in when TFC_ABORT_EN is defined.
module t_ff_burst_ctrl #(
    parameter int PW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [PW-1:0] period,
    input  logic [CW-1:0] count,
`ifdef TFC_ABORT_EN
    input  logic          abort,
`endif
    output logic          t,
    output logic          q,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_t;
    logic          w_t_nxt;
    logic          r_q;
    logic [PW-1:0] r_per_m1;
    logic [PW-1:0] w_per_m1_nxt;
    logic [PW-1:0] r_wait;
    logic [PW-1:0] w_wait_nxt;
    logic [CW-1:0] r_left;
    logic [CW-1:0] w_left_nxt;
    logic          w_abort;

`ifdef TFC_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_t      <= 1'b0;
            r_q      <= 1'b0;
            r_per_m1 <= '0;
            r_wait   <= '0;
            r_left   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_t      <= w_t_nxt;
            r_q      <= r_q ^ r_t;
            r_per_m1 <= w_per_m1_nxt;
            r_wait   <= w_wait_nxt;
            r_left   <= w_left_nxt;
        end
    end

    // r_left = pulses still to issue after the one in flight; r_wait = cycles until the next one.
    always_comb begin
        w_state_nxt  = r_state;
        w_t_nxt      = 1'b0;
        w_per_m1_nxt = r_per_m1;
        w_wait_nxt   = r_wait;
        w_left_nxt   = r_left;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_per_m1_nxt = (period == '0) ? '0 : period - 1'b1;
                    if (count == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_t_nxt     = 1'b1;
                        w_left_nxt  = count - 1'b1;
                        w_wait_nxt  = w_per_m1_nxt;
                    end
                end
            end
            S_RUN: begin
                if (w_abort || (r_left == '0)) begin
                    w_state_nxt = S_DONE;
                end else if (r_wait == '0) begin
                    w_t_nxt    = 1'b1;
                    w_left_nxt = r_left - 1'b1;
                    w_wait_nxt = r_per_m1;
                end else begin
                    w_wait_nxt = r_wait - 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign t    = r_t;
    assign q    = r_q;
    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_t_ff_burst_ctrl.sv
// Bench for t_ff_burst_ctrl: schedule-based model checked every cycle plus literal burst traces.
module tb_t_ff_burst_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] period = '0;
    logic [7:0] count = '0;
`ifdef TFC_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       t, q, busy, done;

    int n_total = 0;
    int n_bad   = 0;

    t_ff_burst_ctrl #(.PW(8), .CW(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .period (period),
        .count  (count),
`ifdef TFC_ABORT_EN
        .abort  (abort),
`endif
        .t      (t),
        .q      (q),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a burst is a schedule relative to the accepting edge E0 (cycle k counts from 1).
    int   m_inb = 0;
    int   m_k   = 0;
    int   m_n   = 0;
    int   m_p   = 1;
    int   m_dc  = 0;
    int   m_cut = 0;
    logic m_q   = 1'b0;

    function logic e_t();
        if (m_inb == 0 || m_k >= m_dc || m_k > m_cut) return 1'b0;
        return (((m_k - 1) % m_p) == 0) && (((m_k - 1) / m_p) < m_n);
    endfunction

    function logic e_busy();
        return (m_inb != 0) && (m_k < m_dc);
    endfunction

    function logic e_done();
        return (m_inb != 0) && (m_k == m_dc);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_inb = 0;
            m_k   = 0;
            m_q   = 1'b0;
        end else begin
            m_q = m_q ^ e_t();
            if (m_inb != 0) begin
                if (m_k == m_dc) begin
                    m_inb = 0;
                end else begin
`ifdef TFC_ABORT_EN
                    if (abort) begin
                        m_cut = m_k;
                        m_dc  = m_k + 1;
                    end
`endif
                    m_k++;
                end
            end else if (start) begin
                m_n   = int'(count);
                m_p   = (period == 0) ? 1 : int'(period);
                m_dc  = (m_n == 0) ? 1 : 2 + (m_n - 1) * m_p;
                m_cut = 1 << 30;
                m_k   = 1;
                m_inb = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_t", 64'(t), 64'(e_t()));
        chk("model_busy", 64'(busy), 64'(e_busy()));
        chk("model_done", 64'(done), 64'(e_done()));
        chk("model_q", 64'(q), 64'(m_q));
    end

    logic [63:0] tr_t, tr_b, tr_d;
    logic        tr_q0, tr_q1;

    // Starts a burst, then records cycles 1..len; xs1/xs2 inject extra starts, xa an abort.
    task automatic run_trace(input int n, input int p, input int len, input int xs1,
                             input int xs2, input int xa, input bit hold);
        tr_t = '0;
        tr_b = '0;
        tr_d = '0;
        @(negedge clk);
        tr_q0  = q;
        start  = 1'b1;
        count  = 8'(n);
        period = 8'(p);
        @(negedge clk);
        for (int k = 1; k <= len; k++) begin
            start = hold || (k == xs1) || (k == xs2);
            if (!hold) begin
                count  = 8'($urandom_range(0, 255));
                period = 8'($urandom_range(0, 255));
            end
`ifdef TFC_ABORT_EN
            abort = (k == xa);
`endif
            tr_t[k] = t;
            tr_b[k] = busy;
            tr_d[k] = done;
            tr_q1   = q;
            @(negedge clk);
        end
        start = 1'b0;
`ifdef TFC_ABORT_EN
        abort = 1'b0;
`endif
        if (xa < 0) return;
    endtask

    task automatic run_long(input int n, input int p, input int exp_dc);
        int k;
        int pulses;
        @(negedge clk);
        start  = 1'b1;
        count  = 8'(n);
        period = 8'(p);
        @(negedge clk);
        start  = 1'b0;
        k      = 1;
        pulses = 0;
        while (!done && k < exp_dc + 10) begin
            if (t) pulses++;
            @(negedge clk);
            k++;
        end
        chk("long_done_cycle", 64'(k), 64'(exp_dc));
        chk("long_pulses", 64'(pulses), 64'(n));
    endtask

    logic [63:0] s_t, s_b, s_d;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_state", {60'd0, t, q, busy, done}, 64'd0);
        reset = 1'b0;

        // Reset mid-burst after q has toggled an odd number of times.
        @(negedge clk);
        start = 1'b1; count = 8'd10; period = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_reset_q", 64'(q), 64'd1);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("async_reset", {60'd0, t, q, busy, done}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_reset", {61'd0, t, busy, done}, 64'd0);
        end

        run_trace(3, 4, 14, -1, -1, -1, 1'b0);
        chk("c3p4_t", tr_t, 64'h222);
        chk("c3p4_busy", tr_b, 64'h3FE);
        chk("c3p4_done", tr_d, 64'h400);
        chk("c3p4_q", {62'd0, tr_q0, tr_q1}, 64'b01);

        run_trace(0, 7, 4, -1, -1, -1, 1'b0);
        chk("c0_t", tr_t, 64'h0);
        chk("c0_busy", tr_b, 64'h0);
        chk("c0_done", tr_d, 64'h2);

        run_trace(4, 0, 7, -1, -1, -1, 1'b0);
        chk("c4p0_t", tr_t, 64'h1E);
        chk("c4p0_busy", tr_b, 64'h1E);
        chk("c4p0_done", tr_d, 64'h20);
        chk("c4p0_q_restored", 64'(tr_q1), 64'(tr_q0));
        s_t = tr_t; s_b = tr_b; s_d = tr_d;
        run_trace(4, 1, 7, -1, -1, -1, 1'b0);
        chk("p1_vs_p0", {tr_t[15:0], tr_b[15:0], tr_d[15:0]}, {s_t[15:0], s_b[15:0], s_d[15:0]});

        run_trace(5, 3, 16, 2, 7, -1, 1'b0);
        chk("ignore_start_t", tr_t, 64'h2492);
        chk("ignore_start_busy", tr_b, 64'h3FFE);
        chk("ignore_start_done", tr_d, 64'h4000);

        run_trace(1, 5, 8, -1, -1, -1, 1'b1);
        chk("held_start_t", tr_t, 64'h92);
        chk("held_start_done", tr_d, 64'h124);
        repeat (3) @(negedge clk);

`ifdef TFC_ABORT_EN
        run_trace(10, 2, 8, -1, -1, 5, 1'b0);
        chk("abort_t", tr_t, 64'h2A);
        chk("abort_busy", tr_b, 64'h3E);
        chk("abort_done", tr_d, 64'h40);
        chk("abort_q", 64'(tr_q1), 64'(~tr_q0));
`endif

        run_long(255, 0, 256);
        run_long(2, 255, 257);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
